// File: rtl/eth_decap_if.sv
// rtl/eth_decap_if.sv - MAC RX stream and TLP FIFO write port bundle for eth_decap
interface eth_decap_if;
  logic        eth_tvalid;
  logic        eth_tready;
  logic        eth_tlast;
  logic [7:0]  eth_tkeep;
  logic [63:0] eth_tdata;
  logic        eth_tuser;
  logic        wr_en;
  logic [63:0] din_tdata;
  logic [7:0]  din_tkeep;
  logic        din_tlast;
  logic        din_tuser;
  logic [3:0]  din_tag;
  logic        full;

  modport slave (
    input  eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser, full,
    output eth_tready, wr_en, din_tdata, din_tkeep, din_tlast, din_tuser, din_tag
  );

  modport master (
    output eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser, full,
    input  eth_tready, wr_en, din_tdata, din_tkeep, din_tlast, din_tuser, din_tag
  );
endinterface

// File: rtl/eth_decap.sv
// rtl/eth_decap.sv - NetTLP RX decapsulator: checks and strips the 48-byte header, forwards TLP payload
module eth_decap #(
  parameter logic [15:0] eth_proto = 16'h0800,
  parameter logic [15:0] udp_dport = 16'h3000,
  parameter bit          CHECK_MAC = 1'b1
) (
  input  logic        eth_clk,
  input  logic        eth_rst_n,
  eth_decap_if.slave  bus,
  input  logic [47:0] mymac,
  input  logic [31:0] dstip,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_drop_cnt
);

  typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_DATA, RX_DROP} rx_state_t;

  rx_state_t       state, state_nxt;
  logic [2:0]      hcnt;
  logic            hdr_ok;
  logic [3:0]      tag_q;
  logic [3:0]      din_tag_q;
  logic [7:0][7:0] b;
  logic [15:0]     dport_off;
  logic            mac_ok, chk, pass, beat, hdr_phase, in_data;

  assign b         = bus.eth_tdata;
  assign dport_off = {b[4], b[5]} - udp_dport;
  assign mac_ok    = (CHECK_MAC == 1'b0) ||
                     ({b[0], b[1], b[2], b[3], b[4], b[5]} == mymac) ||
                     (bus.eth_tdata[47:0] == 48'hFFFF_FFFF_FFFF);

  // Per-qword header checks; qword5 carries nothing we validate.
  always_comb begin
    chk = 1'b1;
    case (hcnt)
      3'd0: chk = mac_ok;
      3'd1: chk = ({b[4], b[5]} == eth_proto) && (b[6] == 8'h45);
      3'd2: chk = (b[7] == 8'd17);
      3'd3: chk = ({b[6], b[7]} == dstip[31:16]);
      3'd4: chk = ({b[0], b[1]} == dstip[15:0]) && (dport_off < 16'd16);
      default: chk = 1'b1;
    endcase
  end

  assign hdr_phase = (state == RX_IDLE) || (state == RX_HDR);
  assign beat      = bus.eth_tvalid & bus.eth_tready;
  assign pass      = hdr_ok & chk;

  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) state <= RX_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE: if (beat) state_nxt = bus.eth_tlast ? RX_IDLE : RX_HDR;
      RX_HDR: begin
        if (beat) begin
          if (bus.eth_tlast)      state_nxt = RX_IDLE;
          else if (hcnt == 3'd5)  state_nxt = pass ? RX_DATA : RX_DROP;
        end
      end
      RX_DATA: if (beat && bus.eth_tlast) state_nxt = RX_IDLE;
      RX_DROP: if (beat && bus.eth_tlast) state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Payload path is combinational; outputs forced to 0 while in reset.
  always_comb begin
    in_data        = eth_rst_n && (state == RX_DATA);
    bus.eth_tready = eth_rst_n && ((state != RX_DATA) || !bus.full);
    bus.wr_en      = in_data && bus.eth_tvalid && !bus.full;
    bus.din_tdata  = in_data ? {b[4], b[5], b[6], b[7], b[0], b[1], b[2], b[3]} : 64'd0;
    bus.din_tkeep  = in_data ? bus.eth_tkeep : 8'd0;
    bus.din_tlast  = in_data && bus.eth_tlast;
    bus.din_tuser  = in_data && bus.eth_tlast && bus.eth_tuser;
  end

  assign bus.din_tag = din_tag_q;

  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) begin
      hcnt        <= 3'd0;
      hdr_ok      <= 1'b1;
      tag_q       <= 4'd0;
      din_tag_q   <= 4'd0;
      rx_pkt_cnt  <= 32'd0;
      rx_drop_cnt <= 32'd0;
    end else begin
      if (beat && hdr_phase) begin
        hcnt   <= (state_nxt == RX_HDR) ? hcnt + 3'd1 : 3'd0;
        hdr_ok <= (state_nxt == RX_HDR) ? pass : 1'b1;
        if (hcnt == 3'd4)
          tag_q <= dport_off[3:0];
        if (state_nxt == RX_DATA)
          din_tag_q <= tag_q;
        if ((state_nxt == RX_IDLE) || (state_nxt == RX_DROP))
          rx_drop_cnt <= rx_drop_cnt + 32'd1;
      end
      if (bus.wr_en && bus.eth_tlast)
        rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// tb/tb_eth_decap.sv - directed bench for eth_decap
module tb_eth_decap;
  logic        eth_clk = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic [47:0] mymac = 48'h02_00_5E_10_20_30;
  logic [31:0] dstip = 32'hC0A8_0A02;
  logic [31:0] rx_pkt_cnt, rx_drop_cnt;

  always #5 eth_clk = ~eth_clk;

  eth_decap_if bus ();

  eth_decap #(.eth_proto(16'h0800), .udp_dport(16'h3000), .CHECK_MAC(1'b1)) dut (
    .eth_clk    (eth_clk),
    .eth_rst_n  (eth_rst_n),
    .bus        (bus),
    .mymac      (mymac),
    .dstip      (dstip),
    .rx_pkt_cnt (rx_pkt_cnt),
    .rx_drop_cnt(rx_drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] cap_d[$];
  logic [7:0]  cap_k[$];
  logic        cap_l[$];
  logic        cap_u[$];
  logic [3:0]  cap_t[$];

  always @(negedge eth_clk) begin
    if (bus.wr_en === 1'b1) begin
      cap_d.push_back(bus.din_tdata);
      cap_k.push_back(bus.din_tkeep);
      cap_l.push_back(bus.din_tlast);
      cap_u.push_back(bus.din_tuser);
      cap_t.push_back(bus.din_tag);
    end
  end

  logic [63:0] frm[$];
  logic [7:0]  last_keep;
  logic        last_user;
  int          stall_beat = -1;
  int          rst_beat = -1;
  int          stall_lo;

  function automatic logic [63:0] swap_exp(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    for (int i = 4; i < 8; i++) r[8*i +: 8] = w[8*(11-i) +: 8];
    return r;
  endfunction

  task automatic clear_cap();
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_u.delete(); cap_t.delete();
  endtask

  task automatic make_frame(input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [31:0] ip, input logic [15:0] dport, input int npay);
    logic [7:0]  hb[48];
    logic [63:0] w;
    for (int i = 0; i < 48; i++) hb[i] = 8'h00;
    for (int i = 0; i < 6; i++) hb[i] = dmac[8*(5-i) +: 8];
    hb[6] = 8'h02; hb[11] = 8'hEE;
    hb[12] = etype[15:8]; hb[13] = etype[7:0];
    hb[14] = 8'h45; hb[23] = 8'd17;
    hb[26] = 8'h0A; hb[29] = 8'h01;
    for (int i = 0; i < 4; i++) hb[30+i] = ip[8*(3-i) +: 8];
    hb[34] = 8'h30; hb[36] = dport[15:8]; hb[37] = dport[7:0];
    frm.delete();
    for (int q = 0; q < 6; q++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = hb[8*q+j];
      frm.push_back(w);
    end
    for (int p = 0; p < npay; p++)
      frm.push_back(64'h0123_4567_89AB_CDEF + 64'(p) * 64'h0101_0101_0101_0101);
    last_keep = 8'hFF;
    last_user = 1'b0;
  endtask

  task automatic send_frame();
    int   n;
    int   t;
    logic acc;
    n = frm.size();
    for (int i = 0; i < n; i++) begin
      bus.eth_tvalid = 1'b1;
      bus.eth_tdata  = frm[i];
      bus.eth_tlast  = (i == n-1);
      bus.eth_tkeep  = (i == n-1) ? last_keep : 8'hFF;
      bus.eth_tuser  = (i == n-1) ? last_user : 1'b0;
      if (i == rst_beat) begin
        eth_rst_n = 1'b0;
        @(posedge eth_clk); #1;
        eth_rst_n = 1'b1;
      end
      if (i == stall_beat) begin
        bus.full = 1'b1;
        repeat (4) begin
          @(negedge eth_clk);
          if (bus.eth_tready === 1'b0) stall_lo++;
          @(posedge eth_clk); #1;
        end
        bus.full = 1'b0;
      end
      t = 0; acc = 1'b0;
      while (!acc && t < 50) begin
        @(negedge eth_clk);
        acc = (bus.eth_tready === 1'b1);
        @(posedge eth_clk); #1;
        t++;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL handshake_timeout beat=%0d tready=%b required=1", i, bus.eth_tready);
      end
    end
    bus.eth_tvalid = 1'b0; bus.eth_tlast = 1'b0; bus.eth_tuser = 1'b0;
    repeat (2) @(posedge eth_clk);
    #1;
  endtask

  task automatic test_reset();
    eth_rst_n = 1'b0;
    bus.eth_tvalid = 1'b1; bus.eth_tdata = 64'hFFFF_FFFF_FFFF_FFFF; bus.eth_tkeep = 8'hFF;
    repeat (2) @(posedge eth_clk);
    @(negedge eth_clk);
    vectors++; if (bus.eth_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got=%b exp=0", bus.eth_tready); end
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    vectors++; if (bus.din_tdata !== 64'd0) begin miscompares++; $display("FAIL reset_din_tdata got=%h exp=0", bus.din_tdata); end
    vectors++; if (bus.din_tag !== 4'd0) begin miscompares++; $display("FAIL reset_din_tag got=%h exp=0", bus.din_tag); end
    vectors++; if (rx_pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_cnt got=%0d exp=0", rx_pkt_cnt); end
    vectors++; if (rx_drop_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_drop_cnt got=%0d exp=0", rx_drop_cnt); end
    bus.eth_tvalid = 1'b0;
    @(posedge eth_clk); #1;
    eth_rst_n = 1'b1;
    @(negedge eth_clk);
    vectors++; if (bus.eth_tready !== 1'b1) begin miscompares++; $display("FAIL idle_tready got=%b exp=1", bus.eth_tready); end
    @(posedge eth_clk); #1;
  endtask

  task automatic test_valid_frame();
    logic [7:0] kexp[3] = '{8'hFF, 8'hFF, 8'h0F};
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3005, 3);
    last_keep = 8'h0F;
    send_frame();
    vectors++; if (cap_d.size() !== 3) begin miscompares++; $display("FAIL valid_writes got=%0d exp=3", cap_d.size()); end
    for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
      vectors++; if (cap_d[i] !== swap_exp(frm[6+i])) begin miscompares++; $display("FAIL valid_data[%0d] got=%h exp=%h", i, cap_d[i], swap_exp(frm[6+i])); end
      vectors++; if (cap_k[i] !== kexp[i]) begin miscompares++; $display("FAIL valid_keep[%0d] got=%h exp=%h", i, cap_k[i], kexp[i]); end
      vectors++; if (cap_l[i] !== (i == 2)) begin miscompares++; $display("FAIL valid_last[%0d] got=%b exp=%b", i, cap_l[i], (i == 2)); end
      vectors++; if (cap_t[i] !== 4'd5) begin miscompares++; $display("FAIL valid_tag[%0d] got=%0d exp=5", i, cap_t[i]); end
      vectors++; if (cap_u[i] !== 1'b0) begin miscompares++; $display("FAIL valid_user[%0d] got=%b exp=0", i, cap_u[i]); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL valid_pkt_cnt got=%0d exp=1", rx_pkt_cnt); end
    vectors++; if (rx_drop_cnt !== 32'd0) begin miscompares++; $display("FAIL valid_drop_cnt got=%0d exp=0", rx_drop_cnt); end
  endtask

  task automatic test_swap();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3000, 1);
    frm[6] = 64'h0706_0504_0302_0100;
    send_frame();
    vectors++; if (cap_d.size() !== 1) begin miscompares++; $display("FAIL swap_writes got=%0d exp=1", cap_d.size()); end
    if (cap_d.size() > 0) begin
      vectors++; if (cap_d[0] !== 64'h0405_0607_0001_0203) begin miscompares++; $display("FAIL swap_data got=%h exp=0405060700010203", cap_d[0]); end
      vectors++; if (cap_t[0] !== 4'd0) begin miscompares++; $display("FAIL swap_tag got=%0d exp=0", cap_t[0]); end
      vectors++; if (cap_l[0] !== 1'b1) begin miscompares++; $display("FAIL swap_last got=%b exp=1", cap_l[0]); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd2) begin miscompares++; $display("FAIL swap_pkt_cnt got=%0d exp=2", rx_pkt_cnt); end
  endtask

  task automatic test_bad_fcs();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h300F, 2);
    last_user = 1'b1;
    send_frame();
    vectors++; if (cap_d.size() !== 2) begin miscompares++; $display("FAIL fcs_writes got=%0d exp=2", cap_d.size()); end
    if (cap_d.size() == 2) begin
      vectors++; if (cap_u[0] !== 1'b0) begin miscompares++; $display("FAIL fcs_user0 got=%b exp=0", cap_u[0]); end
      vectors++; if (cap_u[1] !== 1'b1) begin miscompares++; $display("FAIL fcs_user1 got=%b exp=1", cap_u[1]); end
      vectors++; if (cap_t[1] !== 4'd15) begin miscompares++; $display("FAIL fcs_tag got=%0d exp=15", cap_t[1]); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd3) begin miscompares++; $display("FAIL fcs_pkt_cnt got=%0d exp=3", rx_pkt_cnt); end
    vectors++; if (rx_drop_cnt !== 32'd0) begin miscompares++; $display("FAIL fcs_drop_cnt got=%0d exp=0", rx_drop_cnt); end
  endtask

  task automatic test_filters();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3010, 2);          send_frame();
    make_frame(mymac, 16'h0800, dstip, 16'h2FFF, 2);          send_frame();
    make_frame(mymac, 16'h86DD, dstip, 16'h3001, 2);          send_frame();
    make_frame(mymac ^ 48'h1, 16'h0800, dstip, 16'h3001, 2);  send_frame();
    vectors++; if (cap_d.size() !== 0) begin miscompares++; $display("FAIL filter_writes got=%0d exp=0", cap_d.size()); end
    vectors++; if (rx_drop_cnt !== 32'd4) begin miscompares++; $display("FAIL filter_drop_cnt got=%0d exp=4", rx_drop_cnt); end
    make_frame(48'hFFFF_FFFF_FFFF, 16'h0800, dstip, 16'h3007, 1);
    send_frame();
    vectors++; if (cap_d.size() !== 1) begin miscompares++; $display("FAIL bcast_writes got=%0d exp=1", cap_d.size()); end
    if (cap_d.size() > 0) begin
      vectors++; if (cap_t[0] !== 4'd7) begin miscompares++; $display("FAIL bcast_tag got=%0d exp=7", cap_t[0]); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd4) begin miscompares++; $display("FAIL bcast_pkt_cnt got=%0d exp=4", rx_pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip ^ 32'h1, 16'h3001, 2);
    send_frame();
    make_frame(mymac, 16'h0800, dstip, 16'h3001, 2);
    send_frame();
    vectors++; if (cap_d.size() !== 2) begin miscompares++; $display("FAIL b2b_writes got=%0d exp=2", cap_d.size()); end
    for (int i = 0; i < 2 && i < cap_d.size(); i++) begin
      vectors++; if (cap_d[i] !== swap_exp(frm[6+i])) begin miscompares++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, cap_d[i], swap_exp(frm[6+i])); end
      vectors++; if (cap_t[i] !== 4'd1) begin miscompares++; $display("FAIL b2b_tag[%0d] got=%0d exp=1", i, cap_t[i]); end
    end
    vectors++; if (rx_drop_cnt !== 32'd5) begin miscompares++; $display("FAIL b2b_drop_cnt got=%0d exp=5", rx_drop_cnt); end
    vectors++; if (rx_pkt_cnt !== 32'd5) begin miscompares++; $display("FAIL b2b_pkt_cnt got=%0d exp=5", rx_pkt_cnt); end
  endtask

  task automatic test_stall();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3002, 5);
    stall_lo = 0;
    stall_beat = 8;
    send_frame();
    stall_beat = -1;
    vectors++; if (stall_lo !== 4) begin miscompares++; $display("FAIL stall_tready_low got=%0d exp=4", stall_lo); end
    vectors++; if (cap_d.size() !== 5) begin miscompares++; $display("FAIL stall_writes got=%0d exp=5", cap_d.size()); end
    for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
      vectors++; if (cap_d[i] !== swap_exp(frm[6+i])) begin miscompares++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, cap_d[i], swap_exp(frm[6+i])); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd6) begin miscompares++; $display("FAIL stall_pkt_cnt got=%0d exp=6", rx_pkt_cnt); end
  endtask

  task automatic test_runt();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3003, 0);
    while (frm.size() > 3) void'(frm.pop_back());
    send_frame();
    make_frame(mymac, 16'h0800, dstip, 16'h3003, 0);
    send_frame();
    vectors++; if (cap_d.size() !== 0) begin miscompares++; $display("FAIL runt_writes got=%0d exp=0", cap_d.size()); end
    vectors++; if (rx_drop_cnt !== 32'd7) begin miscompares++; $display("FAIL runt_drop_cnt got=%0d exp=7", rx_drop_cnt); end
    make_frame(mymac, 16'h0800, dstip, 16'h3003, 1);
    send_frame();
    vectors++; if (cap_d.size() !== 1) begin miscompares++; $display("FAIL post_runt_writes got=%0d exp=1", cap_d.size()); end
    vectors++; if (rx_pkt_cnt !== 32'd7) begin miscompares++; $display("FAIL post_runt_pkt_cnt got=%0d exp=7", rx_pkt_cnt); end
  endtask

  task automatic test_reset_midframe();
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3004, 4);
    rst_beat = 7;
    send_frame();
    rst_beat = -1;
    vectors++; if (cap_d.size() !== 1) begin miscompares++; $display("FAIL rst_tail_writes got=%0d exp=1", cap_d.size()); end
    vectors++; if (rx_pkt_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_pkt_cnt got=%0d exp=0", rx_pkt_cnt); end
    vectors++; if (rx_drop_cnt !== 32'd1) begin miscompares++; $display("FAIL rst_drop_cnt got=%0d exp=1", rx_drop_cnt); end
    clear_cap();
    make_frame(mymac, 16'h0800, dstip, 16'h3006, 2);
    send_frame();
    vectors++; if (cap_d.size() !== 2) begin miscompares++; $display("FAIL rst_next_writes got=%0d exp=2", cap_d.size()); end
    if (cap_d.size() > 0) begin
      vectors++; if (cap_t[0] !== 4'd6) begin miscompares++; $display("FAIL rst_next_tag got=%0d exp=6", cap_t[0]); end
    end
    vectors++; if (rx_pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL rst_next_pkt_cnt got=%0d exp=1", rx_pkt_cnt); end
  endtask

  initial begin
    bus.eth_tvalid = 1'b0; bus.eth_tlast = 1'b0; bus.eth_tkeep = 8'h00;
    bus.eth_tdata = 64'd0; bus.eth_tuser = 1'b0; bus.full = 1'b0;
    test_reset();
    test_valid_frame();
    test_swap();
    test_bad_fcs();
    test_filters();
    test_back_to_back();
    test_stall();
    test_runt();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
